mc_control_fsm: RTL and testbench

//  Multicycle control sequencer for the 16-bit datapath: drives the load enables of the

---
 rtl/mc_control_fsm_pkg.sv | 53 +++++
 rtl/mc_control_fsm_if.sv | 38 +++
 rtl/mc_control_fsm.sv | 166 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control sequencer and the datapath that
// decodes its mux selects.
package mc_control_fsm_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_HLT   = 4'hF;

  localparam logic [1:0] ALUB_B     = 2'b00;
  localparam logic [1:0] ALUB_ONE   = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13,
    S_TRAP   = 4'd14
  } state_e;

  function automatic state_e decode_next(input logic [3:0] op);
    case (op)
      OP_RTYPE:      return S_EXEC;
      OP_ADDI:       return S_IEXEC;
      OP_LW, OP_SW:  return S_MEMADR;
      OP_BEQ:        return S_BRANCH;
      OP_JMP:        return S_JUMP;
      OP_HLT:        return S_HALT;
      default:       return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface mc_control_fsm_if #(parameter int STATE_W = 4);
  logic [3:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_we;
  logic               ir_we;
  logic               mdr_we;
  logic               ab_we;
  logic               aluout_we;
  logic               rf_we;
  logic               mem_rd;
  logic               mem_wr;
  logic               iord;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               halted;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_we, ir_we, mdr_we, ab_we, aluout_we, rf_we, mem_rd, mem_wr,
           iord, alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg,
           halted, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_we, ir_we, mdr_we, ab_we, aluout_we, rf_we, mem_rd, mem_wr,
           iord, alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg,
           halted, illegal, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: one registered state, combinational next-state
// and output decode. Only FETCH/MEMRD (mem_ready) and BRANCH (zero) are Mealy.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input logic              clk,
  input logic              rst_n,
  mc_control_fsm_if.master bus
);

  state_e     state_q, state_d;
  logic       is_sw_q, is_sw_d;
  logic       mem_ok_s;
  logic       pc_we_s, ir_we_s, mdr_we_s, ab_we_s, aluout_we_s, rf_we_s;
  logic       mem_rd_s, mem_wr_s, iord_s, alu_src_a_s, reg_dst_s, mem_to_reg_s;
  logic       halted_s, illegal_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_src_s;

  assign mem_ok_s = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;

  // State register; LW/SW distinction is captured in DECODE so opcode is not re-read later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    is_sw_d      = is_sw_q;
    pc_we_s      = 1'b0;
    ir_we_s      = 1'b0;
    mdr_we_s     = 1'b0;
    ab_we_s      = 1'b0;
    aluout_we_s  = 1'b0;
    rf_we_s      = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    iord_s       = 1'b0;
    alu_src_a_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    halted_s     = 1'b0;
    illegal_s    = 1'b0;
    alu_src_b_s  = ALUB_B;
    alu_op_s     = ALUOP_ADD;
    pc_src_s     = PCSRC_ALU;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_rd_s    = 1'b1;
        alu_src_b_s = ALUB_ONE;
        if (mem_ok_s) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ab_we_s     = 1'b1;
        aluout_we_s = 1'b1;
        alu_src_b_s = ALUB_IMM;
        is_sw_d     = (bus.opcode == OP_SW);
        state_d     = decode_next(bus.opcode);
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = ALUB_IMM;
        aluout_we_s = 1'b1;
        state_d     = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_rd_s = 1'b1;
        iord_s   = 1'b1;
        if (mem_ok_s) begin
          mdr_we_s = 1'b1;
          state_d  = S_MEMWB;
        end else begin
          state_d  = S_MEMRD;
        end
      end
      S_MEMWB: begin
        rf_we_s      = 1'b1;
        mem_to_reg_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr_s = 1'b1;
        iord_s   = 1'b1;
        state_d  = mem_ok_s ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_FUNC;
        aluout_we_s = 1'b1;
        state_d     = S_RWB;
      end
      S_RWB: begin
        rf_we_s   = 1'b1;
        reg_dst_s = 1'b1;
        state_d   = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = ALUB_IMM;
        aluout_we_s = 1'b1;
        state_d     = S_IWB;
      end
      S_IWB: begin
        rf_we_s = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_SUB;
        pc_src_s    = PCSRC_OUT;
        pc_we_s     = bus.zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src_s = PCSRC_JMP;
        pc_we_s  = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
        state_d  = S_HALT;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
        state_d   = S_TRAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pc_we      = pc_we_s;
  assign bus.ir_we      = ir_we_s;
  assign bus.mdr_we     = mdr_we_s;
  assign bus.ab_we      = ab_we_s;
  assign bus.aluout_we  = aluout_we_s;
  assign bus.rf_we      = rf_we_s;
  assign bus.mem_rd     = mem_rd_s;
  assign bus.mem_wr     = mem_wr_s;
  assign bus.iord       = iord_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.pc_src     = pc_src_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.halted     = halted_s;
  assign bus.illegal    = illegal_s;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench: one DUT with mem_ready handshake, one with single-cycle memory.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  // Packed control view: pc_we ir_we mdr_we ab_we aluout_we rf_we mem_rd mem_wr iord alu_src_a
  //                      | alu_src_b alu_op pc_src | reg_dst mem_to_reg halted illegal
  localparam logic [19:0] C_ZERO    = 20'b0000000000_000000_0000;
  localparam logic [19:0] C_FETCH_R = 20'b1100001000_010000_0000;
  localparam logic [19:0] C_FETCH_W = 20'b0000001000_010000_0000;
  localparam logic [19:0] C_DECODE  = 20'b0001100000_100000_0000;
  localparam logic [19:0] C_MEMADR  = 20'b0000100001_100000_0000;
  localparam logic [19:0] C_MEMRD_R = 20'b0010001010_000000_0000;
  localparam logic [19:0] C_MEMRD_W = 20'b0000001010_000000_0000;
  localparam logic [19:0] C_MEMWB   = 20'b0000010000_000000_0100;
  localparam logic [19:0] C_MEMWR   = 20'b0000000110_000000_0000;
  localparam logic [19:0] C_EXEC    = 20'b0000100001_001000_0000;
  localparam logic [19:0] C_RWB     = 20'b0000010000_000000_1000;
  localparam logic [19:0] C_IEXEC   = 20'b0000100001_100000_0000;
  localparam logic [19:0] C_IWB     = 20'b0000010000_000000_0000;
  localparam logic [19:0] C_BR_T    = 20'b1000000001_000101_0000;
  localparam logic [19:0] C_BR_N    = 20'b0000000001_000101_0000;
  localparam logic [19:0] C_JUMP    = 20'b1000000000_000010_0000;
  localparam logic [19:0] C_HALT    = 20'b0000000000_000000_0010;
  localparam logic [19:0] C_TRAP    = 20'b0000000000_000000_0001;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   overlap_cnt;

  mc_control_fsm_if #(.STATE_W(4)) bus_a ();
  mc_control_fsm_if #(.STATE_W(4)) bus_b ();

  mc_control_fsm #(.USE_MEM_READY(1), .STATE_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mc_control_fsm #(.USE_MEM_READY(0), .STATE_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [19:0] ctl_a;
  logic [19:0] ctl_b;
  assign ctl_a = {bus_a.pc_we, bus_a.ir_we, bus_a.mdr_we, bus_a.ab_we, bus_a.aluout_we,
                  bus_a.rf_we, bus_a.mem_rd, bus_a.mem_wr, bus_a.iord, bus_a.alu_src_a,
                  bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_src,
                  bus_a.reg_dst, bus_a.mem_to_reg, bus_a.halted, bus_a.illegal};
  assign ctl_b = {bus_b.pc_we, bus_b.ir_we, bus_b.mdr_we, bus_b.ab_we, bus_b.aluout_we,
                  bus_b.rf_we, bus_b.mem_rd, bus_b.mem_wr, bus_b.iord, bus_b.alu_src_a,
                  bus_b.alu_src_b, bus_b.alu_op, bus_b.pc_src,
                  bus_b.reg_dst, bus_b.mem_to_reg, bus_b.halted, bus_b.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((bus_a.mem_rd && bus_a.mem_wr) || (bus_b.mem_rd && bus_b.mem_wr)) overlap_cnt++;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus_a.state !== 4'(S_IDLE) || ctl_a !== C_ZERO) begin
      tests_failed++;
      $display("FAIL reset_hold: state=%0d ctl=%b, expected state=%0d ctl=%b", bus_a.state, ctl_a, S_IDLE, C_ZERO);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus_a.state !== 4'(S_IDLE)) begin
      tests_failed++;
      $display("FAIL reset_release_idle: state=%0d, expected %0d", bus_a.state, S_IDLE);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus_a.state !== 4'(S_FETCH) || ctl_a !== C_FETCH_W) begin
      tests_failed++;
      $display("FAIL reset_first_fetch: state=%0d ctl=%b, expected state=%0d ctl=%b", bus_a.state, ctl_a, S_FETCH, C_FETCH_W);
    end
  endtask

  task automatic test_rtype();
    state_e      st  [5] = '{S_FETCH, S_DECODE, S_EXEC, S_RWB, S_FETCH};
    logic [19:0] ctl [5] = '{C_FETCH_R, C_DECODE, C_EXEC, C_RWB, C_FETCH_W};
    logic        rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus_a.opcode = OP_RTYPE; bus_a.mem_ready = rdy[i]; bus_a.zero = 1'b0;
      #1;
      tests_run++;
      if (bus_a.state !== 4'(st[i]) || ctl_a !== ctl[i]) begin
        tests_failed++;
        $display("FAIL rtype step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus_a.state, ctl_a, st[i], ctl[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    state_e      st  [9] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB, S_FETCH};
    logic [19:0] ctl [9] = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMRD_W, C_MEMRD_W, C_MEMRD_W, C_MEMRD_R, C_MEMWB, C_FETCH_W};
    logic        rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  op  [9] = '{4'h2, 4'h2, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < 9; i++) begin
      bus_a.opcode = op[i]; bus_a.mem_ready = rdy[i]; bus_a.zero = 1'b0;
      #1;
      tests_run++;
      if (bus_a.state !== 4'(st[i]) || ctl_a !== ctl[i]) begin
        tests_failed++;
        $display("FAIL lw_wait step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus_a.state, ctl_a, st[i], ctl[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    state_e      st  [7] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
    logic [19:0] ctl [7] = '{C_FETCH_R, C_DECODE, C_BR_T, C_FETCH_R, C_DECODE, C_BR_N, C_FETCH_W};
    logic        rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        zr  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      bus_a.opcode = OP_BEQ; bus_a.mem_ready = rdy[i]; bus_a.zero = zr[i];
      #1;
      tests_run++;
      if (bus_a.state !== 4'(st[i]) || ctl_a !== ctl[i]) begin
        tests_failed++;
        $display("FAIL beq step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus_a.state, ctl_a, st[i], ctl[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_jmp_sw();
    state_e      st  [13] = '{S_FETCH, S_DECODE, S_IEXEC, S_IWB, S_FETCH, S_DECODE, S_JUMP,
                              S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_FETCH};
    logic [19:0] ctl [13] = '{C_FETCH_R, C_DECODE, C_IEXEC, C_IWB, C_FETCH_R, C_DECODE, C_JUMP,
                              C_FETCH_R, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR, C_FETCH_W};
    logic        rdy [13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  op  [13] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h5, 4'h5, 4'h5,
                              4'h3, 4'h3, 4'h2, 4'h2, 4'h3, 4'h0};
    for (int i = 0; i < 13; i++) begin
      bus_a.opcode = op[i]; bus_a.mem_ready = rdy[i]; bus_a.zero = 1'b1;
      #1;
      tests_run++;
      if (bus_a.state !== 4'(st[i]) || ctl_a !== ctl[i]) begin
        tests_failed++;
        $display("FAIL addi_jmp_sw step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus_a.state, ctl_a, st[i], ctl[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    bus_a.opcode = 4'h7; bus_a.mem_ready = 1'b1; bus_a.zero = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus_a.state !== 4'(S_DECODE)) begin
      tests_failed++;
      $display("FAIL trap_decode: state=%0d, expected %0d", bus_a.state, S_DECODE);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus_a.opcode = 4'(i); bus_a.mem_ready = i[0]; bus_a.zero = i[1];
      #1;
      tests_run++;
      if (bus_a.state !== 4'(S_TRAP) || ctl_a !== C_TRAP) begin
        tests_failed++;
        $display("FAIL trap_sticky cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus_a.state, ctl_a, S_TRAP, C_TRAP);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus_a.opcode = OP_HLT; bus_a.mem_ready = 1'b1; bus_a.zero = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus_a.opcode = 4'(i); bus_a.mem_ready = i[0];
      #1;
      tests_run++;
      if (bus_a.state !== 4'(S_HALT) || ctl_a !== C_HALT) begin
        tests_failed++;
        $display("FAIL halt_sticky cycle %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus_a.state, ctl_a, S_HALT, C_HALT);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_memrd();
    do_reset();
    bus_a.opcode = OP_LW; bus_a.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_a.mem_ready = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (bus_a.state !== 4'(S_MEMRD) || ctl_a !== C_MEMRD_W) begin
      tests_failed++;
      $display("FAIL mid_memrd_reach: state=%0d ctl=%b, expected state=%0d ctl=%b", bus_a.state, ctl_a, S_MEMRD, C_MEMRD_W);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_a.state !== 4'(S_IDLE) || ctl_a !== C_ZERO) begin
      tests_failed++;
      $display("FAIL mid_memrd_async: state=%0d ctl=%b, expected state=%0d ctl=%b", bus_a.state, ctl_a, S_IDLE, C_ZERO);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus_a.state !== 4'(S_IDLE) || ctl_a !== C_ZERO) begin
      tests_failed++;
      $display("FAIL mid_memrd_idle: state=%0d ctl=%b, expected state=%0d ctl=%b", bus_a.state, ctl_a, S_IDLE, C_ZERO);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus_a.state !== 4'(S_FETCH)) begin
      tests_failed++;
      $display("FAIL mid_memrd_fetch: state=%0d, expected %0d", bus_a.state, S_FETCH);
    end
  endtask

  task automatic test_no_ready_sw();
    state_e      st  [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
    logic [19:0] ctl [5] = '{C_FETCH_R, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH_R};
    bus_b.opcode = OP_SW;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (bus_b.state !== 4'(st[i]) || ctl_b !== ctl[i]) begin
        tests_failed++;
        $display("FAIL no_ready_sw step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus_b.state, ctl_b, st[i], ctl[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; overlap_cnt = 0;
    rst_n = 1'b0;
    bus_a.opcode = 4'h0; bus_a.zero = 1'b0; bus_a.mem_ready = 1'b0;
    bus_b.opcode = 4'h0; bus_b.zero = 1'b0; bus_b.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_addi_jmp_sw();
    test_trap();
    test_halt();
    test_reset_mid_memrd();
    test_no_ready_sw();
    tests_run++;
    if (overlap_cnt !== 0) begin
      tests_failed++;
      $display("FAIL rd_wr_overlap: overlap cycles=%0d, expected 0", overlap_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
